// File: rtl/uart_tx_buffered_pkg.sv
// Shared types for the buffered UART transmitter.
// Holds the FSM state enum, oversample ratio and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int OVERSAMPLE = 16;

    // data is zero-extended by the caller, so extra bits do not flip parity
    function automatic logic calc_parity(
        input logic [8:0] data,
        input logic       odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side bus of the buffered UART transmitter.
// Ports: wr_en/w_data/parity_odd (to tx), full/overflow/fifo_level (from tx).
interface uart_tx_buffered_if #(
    parameter int DBIT    = 8,
    parameter int FIFO_AW = 4
);
    logic              wr_en;
    logic [DBIT-1:0]   w_data;
    logic              parity_odd;
    logic              full;
    logic              overflow;
    logic [FIFO_AW:0]  fifo_level;

    modport master (
        output wr_en, w_data, parity_odd,
        input  full, overflow, fifo_level
    );

    modport slave (
        input  wr_en, w_data, parity_odd,
        output full, overflow, fifo_level
    );
endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO (uart_sync_fifo) holding frames waiting for the line.
// Ports: push_i/wdata_i in, pop_i in, rdata_o (head), level_o, full_o, empty_o.
module uart_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q;
    logic          do_push, do_pop;

    // full is the registered pre-cycle state: a push while full is
    // dropped even if a pop frees a slot in the same cycle
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rp_q];
    assign level_o = level_q;
    assign full_o  = full_q;
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO + 16x tick generator + frame FSM.
// Ports: clk, reset_n, bus (slave: push side), data_out (serial pin),
//   tx_done_tick (end of stop bit), tx_ready (idle with empty FIFO).
// Build option: define UART_TX_PARITY_EN to insert a parity bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int FIFO_AW = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_tx_buffered_if.slave     bus,
    output logic                  data_out,
    output logic                  tx_done_tick,
    output logic                  tx_ready
);
    localparam int CW = $clog2(DVSR);
    localparam int NW = $clog2(DBIT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            data_out_q, data_out_d;
    logic            done_q, done_d;
    logic            ovf_q;
    logic            tick, pop;
    logic            fifo_empty, fifo_full;
    logic [DBIT-1:0] fifo_rdata;
    logic [FIFO_AW:0] fifo_level;

    uart_sync_fifo #(
        .DW (DBIT),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (bus.wr_en),
        .wdata_i (bus.w_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) par_q <= 1'b0;
        else          par_q <= par_d;
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = bus.parity_odd;
`endif

    // Restarting the divider on pop aligns every bit to the frame start
    assign tick = (cnt_q == CW'(DVSR - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (pop || tick) cnt_d = '0;
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        pop     = 1'b0;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = calc_parity(9'(fifo_rdata),
                                          bus.parity_odd);
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 5'(OVERSAMPLE - 1)) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 5'(OVERSAMPLE - 1)) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == 5'(OVERSAMPLE - 1)) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == 5'(SB_TICK - 1)) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin level is decoded from the next state so it can be registered
    // without adding a cycle of latency to each bit boundary
    always_comb begin
        data_out_d = 1'b1;
        unique case (state_d)
            START:   data_out_d = 1'b0;
            DATA:    data_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  data_out_d = par_d;
`endif
            default: data_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s_q        <= '0;
            n_q        <= '0;
            shift_q    <= '0;
            data_out_q <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            n_q        <= n_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            ovf_q      <= bus.wr_en && fifo_full;
        end
    end

    assign bus.full       = fifo_full;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_level = fifo_level;
    assign data_out       = data_out_q;
    assign tx_done_tick   = done_q;
    assign tx_ready       = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: waveform-level reference model
// compared every cycle, plus directed literal timing checks.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int DVSR    = 4;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int BITC    = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB    = 1 + DBIT + PB;
    localparam int FRAME = NB * BITC + SB_TICK * DVSR;

    logic clk = 1'b0;
    logic reset_n;
    logic data_out, tx_done_tick, tx_ready;

    uart_tx_buffered_if #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) bus();

    uart_tx_buffered #(
        .DBIT(DBIT), .SB_TICK(SB_TICK),
        .DVSR(DVSR), .FIFO_AW(FIFO_AW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .data_out     (data_out),
        .tx_done_tick (tx_done_tick),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     name, got, want, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference model: queue of stored bytes and position in current frame
    logic [DBIT-1:0] mq[$];
    logic [DBIT-1:0] m_cur = '0;
    logic m_par = 1'b0;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic m_ovf = 1'b0;
    int   m_t = 0;

    function automatic logic exp_line();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / BITC;
        if (k == 0) return 1'b0;
        if (k <= DBIT) return m_cur[k-1];
        if (PB == 1 && k == DBIT + 1) return (^m_cur) ^ m_par;
        return 1'b1;
    endfunction

    initial forever begin
        int pre;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_t    = 0;
        end else begin
            pre = mq.size();
            m_done = 1'b0;
            if (m_busy) begin
                if (m_t == FRAME - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_t++;
                end
            end else if (pre > 0) begin
                m_cur  = mq.pop_front();
                m_par  = bus.parity_odd;
                m_busy = 1'b1;
                m_t    = 0;
            end
            m_ovf = bus.wr_en && (pre == DEPTH);
            if (bus.wr_en && pre != DEPTH) mq.push_back(bus.w_data);
        end
    end

    initial forever begin
        @(negedge clk);
        check("data_out", data_out, exp_line());
        check("tx_done_tick", tx_done_tick, m_done);
        check("overflow", bus.overflow, m_ovf);
        check("full", bus.full, mq.size() == DEPTH);
        check("fifo_level", bus.fifo_level, mq.size());
        check("tx_ready", tx_ready, !m_busy && mq.size() == 0);
        if (tx_done_tick === 1'b1) done_cnt++;
    end

    task automatic drive(input logic we, input logic [DBIT-1:0] d);
        @(negedge clk);
        #1;
        bus.wr_en  = we;
        bus.w_data = d;
    endtask

    task automatic wait_low(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_out === 1'b0) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) timeout("wait_line_low");
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_done_tick === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) timeout("wait_done");
    endtask

    task automatic wait_ready(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) timeout("wait_ready");
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int n0, ts, td, s2, dc0;
        logic [10:0] exp1;
        reset_n        = 1'b0;
        bus.wr_en      = 1'b0;
        bus.w_data     = '0;
        bus.parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_level", bus.fifo_level, 0);
        check("rst_full", bus.full, 0);
        check("rst_done", tx_done_tick, 0);
        check("rst_overflow", bus.overflow, 0);
        #1 reset_n = 1'b1;

        // single 0x55 frame, literal bit pattern and timing
`ifdef UART_TX_PARITY_EN
        exp1 = 11'b10010101010;
`else
        exp1 = 11'b01010101010;
`endif
        drive(1'b1, 8'h55);
        n0 = cyc;
        drive(1'b0, '0);
        wait_low(10, ts);
        check("t1_start_latency", ts - n0, 2);
        for (int k = 0; k <= NB; k++) begin
            wait_cyc(ts + BITC / 2 + k * BITC);
            check("t1_bit", data_out, exp1[k]);
        end
        wait_done(2 * FRAME, td);
`ifdef UART_TX_PARITY_EN
        check("t1_frame_len", td - ts, 704);
`else
        check("t1_frame_len", td - ts, 640);
`endif
        check("t1_ready", tx_ready, 1);

        // back-to-back frames, 1 clk gap
        wait_ready(100);
        dc0 = done_cnt;
        drive(1'b1, 8'hA3);
        drive(1'b1, 8'h0F);
        drive(1'b1, 8'hFF);
        drive(1'b0, '0);
        wait_done(2 * FRAME, td);
        wait_low(10, s2);
        check("t2_gap", s2 - td, 1);
        wait_done(2 * FRAME, td);
        wait_done(2 * FRAME, td);
        repeat (2) @(negedge clk);
        check("t2_done_count", done_cnt - dc0, 3);

        // fill to full during a frame, then overflow
        wait_ready(100);
        drive(1'b1, 8'h10);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h20 + 8'(i));
        drive(1'b1, 8'hEE);
        check("t3_level_full", bus.fifo_level, 16);
        check("t3_full", bus.full, 1);
        drive(1'b0, '0);
        check("t3_overflow", bus.overflow, 1);
        check("t3_level_after", bus.fifo_level, 16);
        dc0 = done_cnt;
        @(negedge clk);
        check("t3_overflow_pulse", bus.overflow, 0);
        wait_ready((DEPTH + 2) * (FRAME + 2));
        repeat (2) @(negedge clk);
        check("t3_frames", done_cnt - dc0, 17);

`ifdef UART_TX_PARITY_EN
        // parity bit for 0x07, even then odd
        bus.parity_odd = 1'b0;
        drive(1'b1, 8'h07);
        drive(1'b0, '0);
        wait_low(10, ts);
        wait_cyc(ts + BITC / 2 + (DBIT + 1) * BITC);
        check("t5_parity_even", data_out, 1);
        wait_done(2 * FRAME, td);
        check("t5_frame_len", td - ts, 704);
        wait_ready(100);
        bus.parity_odd = 1'b1;
        drive(1'b1, 8'h07);
        drive(1'b0, '0);
        wait_low(10, ts);
        wait_cyc(ts + BITC / 2 + (DBIT + 1) * BITC);
        check("t5_parity_odd", data_out, 0);
        wait_ready(2 * FRAME);
`endif

        // reset in the middle of the data bits
        wait_ready(100);
        drive(1'b1, 8'h3C);
        drive(1'b1, 8'hC3);
        drive(1'b0, '0);
        wait_low(10, ts);
        wait_cyc(ts + 3 * BITC + 10);
        check("t6_level_pre", bus.fifo_level, 1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6_data_out", data_out, 1);
        check("t6_level", bus.fifo_level, 0);
        check("t6_ready", tx_ready, 1);
        check("t6_full", bus.full, 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        drive(1'b1, 8'h81);
        drive(1'b0, '0);
        wait_low(10, ts);
        wait_done(2 * FRAME, td);
        check("t6_frame_len", td - ts, FRAME);

        // random traffic, including pushes into a full FIFO
        wait_ready(100);
        for (int i = 0; i < 5000; i++) begin
            bus.parity_odd = 1'($urandom);
            drive($urandom_range(0, 39) == 0, DBIT'($urandom));
        end
        drive(1'b0, '0);
        wait_ready((DEPTH + 2) * (FRAME + 2));
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
